// File: rtl/sync_sched.sv
// Round-robin scheduler that turns digital boundary-net changes into one-at-a-time sync records.
// Optional macro SYNC_SCHED_TIMEOUT_EN adds a SEND timeout that re-queues the record and sets a sticky err.
module sync_sched #(
    parameter int   N_REQ   = 4,
    parameter int   TIMEOUT = 15,
    parameter logic init_v  = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           d_in,
    input  logic                       sync_ack,
    output logic                       sync_valid,
    output logic [$clog2(N_REQ)-1:0]   sync_idx,
    output logic                       sync_val,
    output logic [N_REQ-1:0]           pending,
    output logic                       err
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] d_q;
    logic [N_REQ-1:0] cap, cap_d;
    logic [N_REQ-1:0] chg;
    logic [N_REQ-1:0] pend_d;
    logic [IW-1:0]    rr_ptr, ptr_d;
    logic [IW-1:0]    idx_d;
    logic             valid_d, val_d;
    logic             found;
    logic [IW-1:0]    pick;

`ifdef SYNC_SCHED_TIMEOUT_EN
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Cyclic (base + off) mod N_REQ, valid for any N_REQ, not only powers of two.
    function automatic logic [IW-1:0] next_pos(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    assign chg = d_in ^ d_q;

    // First pending net at or after rr_ptr, searching cyclically.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && pending[next_pos(rr_ptr, k)]) begin
                found = 1'b1;
                pick  = next_pos(rr_ptr, k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = sync_valid;
        idx_d   = sync_idx;
        val_d   = sync_val;
        ptr_d   = rr_ptr;
        pend_d  = pending | chg;
        cap_d   = (cap & ~chg) | (d_in & chg);
`ifdef SYNC_SCHED_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d      = SEND;
                    valid_d      = 1'b1;
                    idx_d        = pick;
                    val_d        = cap[pick];
                    // A change landing on the grant edge keeps the net pending.
                    pend_d[pick] = chg[pick];
`ifdef SYNC_SCHED_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            SEND: begin
                if (sync_ack) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    ptr_d   = next_pos(sync_idx, 1);
                end
`ifdef SYNC_SCHED_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d          = IDLE;
                    valid_d          = 1'b0;
                    ptr_d            = next_pos(sync_idx, 1);
                    pend_d[sync_idx] = 1'b1;
                    err_d            = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_valid <= 1'b0;
            sync_idx   <= '0;
            sync_val   <= 1'b0;
            pending    <= '0;
            rr_ptr     <= '0;
            // NOTE: the net history is reset too; a stale d_q after reset would report changes that never happened.
            d_q        <= {N_REQ{init_v}};
            cap        <= {N_REQ{init_v}};
`ifdef SYNC_SCHED_TIMEOUT_EN
            err_q      <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            sync_valid <= valid_d;
            sync_idx   <= idx_d;
            sync_val   <= val_d;
            pending    <= pend_d;
            rr_ptr     <= ptr_d;
            d_q        <= d_in;
            cap        <= cap_d;
`ifdef SYNC_SCHED_TIMEOUT_EN
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_sync_sched.sv
// Directed bench for sync_sched: change detect, round-robin order, coalescing, in-flight changes,
// timeout (when SYNC_SCHED_TIMEOUT_EN is defined) and asynchronous reset mid-record.
module tb_sync_sched;

`ifdef SYNC_SCHED_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] d_in;
    logic       sync_ack;
    logic       sync_valid;
    logic [1:0] sync_idx;
    logic       sync_val;
    logic [3:0] pending;
    logic       err;

    int total = 0;
    int bad   = 0;

    sync_sched #(.N_REQ(4), .TIMEOUT(TO), .init_v(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .d_in       (d_in),
        .sync_ack   (sync_ack),
        .sync_valid (sync_valid),
        .sync_idx   (sync_idx),
        .sync_val   (sync_val),
        .pending    (pending),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!sync_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", 32'(sync_valid), 1);
    endtask

    // Expect a record, check it, ack it for one edge and confirm it is withdrawn.
    task automatic take(input int exp_idx, input int exp_val);
        wait_valid();
        check("rec_idx", 32'(sync_idx), exp_idx);
        check("rec_val", 32'(sync_val), exp_val);
        sync_ack = 1'b1;
        @(negedge clk);
        sync_ack = 1'b0;
        check("rec_drop", 32'(sync_valid), 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        d_in     = 4'b0000;
        en       = 1'b1;
        sync_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        d_in     = 4'b0000;
        sync_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(sync_valid), 0);
        check("rst_idx",   32'(sync_idx),   0);
        check("rst_val",   32'(sync_val),   0);
        check("rst_pend",  32'(pending),    0);
        check("rst_err",   32'(err),        0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_spur_pend",  32'(pending),    0);
        check("no_spur_valid", 32'(sync_valid), 0);

        // Single change on net 2: pending after edge k, record after edge k+1, one cycle with immediate ack.
        d_in = 4'b0100;
        @(negedge clk);
        check("t1_pend",    32'(pending),    4);
        check("t1_early",   32'(sync_valid), 0);
        @(negedge clk);
        check("t1_valid",   32'(sync_valid), 1);
        check("t1_idx",     32'(sync_idx),   2);
        check("t1_val",     32'(sync_val),   1);
        check("t1_pclr",    32'(pending),    0);
        sync_ack = 1'b1;
        @(negedge clk);
        sync_ack = 1'b0;
        check("t1_drop",    32'(sync_valid), 0);
        check("t1_pend0",   32'(pending),    0);
        @(negedge clk);
        check("t1_once",    32'(sync_valid), 0);

        // Round-robin from rr_ptr=0, wrap after 3, then cyclic search from 2.
        do_reset();
        d_in = 4'b1111;
        take(0, 1);
        take(1, 1);
        take(2, 1);
        take(3, 1);
        check("rr_pend0", 32'(pending), 0);
        d_in = 4'b1100;
        take(0, 0);
        take(1, 0);
        d_in = 4'b0101;
        take(3, 0);
        take(0, 1);

        // Coalesce while en=0: three changes on net 1 give one record with the latest value.
        en   = 1'b0;
        d_in = 4'b0111;
        @(negedge clk);
        d_in = 4'b0101;
        @(negedge clk);
        d_in = 4'b0111;
        repeat (2) @(negedge clk);
        check("co_blocked", 32'(sync_valid), 0);
        check("co_pend",    32'(pending),    2);
        en = 1'b1;
        take(1, 1);
        check("co_pend0",   32'(pending),    0);
        repeat (2) @(negedge clk);
        check("co_once",    32'(sync_valid), 0);

        // Change on net 2 at its own grant edge: offered value is pre-edge, net stays pending.
        d_in = 4'b0011;
        @(negedge clk);
        d_in = 4'b0111;
        @(negedge clk);
        check("sw_valid", 32'(sync_valid), 1);
        check("sw_idx",   32'(sync_idx),   2);
        check("sw_val",   32'(sync_val),   0);
        check("sw_pend",  32'(pending),    4);
        take(2, 0);
        take(2, 1);

        // In-flight changes on net 3 while its record waits for ack.
        d_in = 4'b1111;
        wait_valid();
        check("if_idx",   32'(sync_idx), 3);
        check("if_val",   32'(sync_val), 1);
        d_in = 4'b0111;
        @(negedge clk);
        check("if_hold1", {29'd0, sync_valid, sync_idx}, 7);
        check("if_val1",  32'(sync_val), 1);
        check("if_pend1", 32'(pending),  8);
        d_in = 4'b1111;
        @(negedge clk);
        check("if_hold2", {29'd0, sync_valid, sync_idx}, 7);
        check("if_val2",  32'(sync_val), 1);
        check("if_pend2", 32'(pending),  8);
        take(3, 1);
        take(3, 1);
        check("if_pend0", 32'(pending),  0);

        // Record on net 0 left without ack.
        d_in = 4'b1110;
        wait_valid();
        check("na_idx", 32'(sync_idx), 0);
        check("na_val", 32'(sync_val), 0);
`ifdef SYNC_SCHED_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("to_hold", 32'(sync_valid), 1);
        end
        @(negedge clk);
        check("to_drop", 32'(sync_valid), 0);
        check("to_err",  32'(err),        1);
        check("to_pend", 32'(pending),    1);
        @(negedge clk);
        check("to_regrant", 32'(sync_valid), 1);
        check("to_reidx",   32'(sync_idx),   0);
        check("to_err_stk", 32'(err),        1);
`else
        repeat (20) @(negedge clk);
        check("na_hold", 32'(sync_valid), 1);
        check("na_idx2", 32'(sync_idx),   0);
        check("na_err",  32'(err),        0);
`endif
        d_in = 4'b1100;
        take(0, 0);
        wait_valid();
        check("ms_idx", 32'(sync_idx), 1);
        check("ms_val", 32'(sync_val), 0);
        d_in = 4'b1000;
        @(negedge clk);
        check("ms_pend", 32'(pending), 4);

        // Asynchronous reset in the middle of SEND: everything clears before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(sync_valid), 0);
        check("ar_idx",   32'(sync_idx),   0);
        check("ar_val",   32'(sync_val),   0);
        check("ar_pend",  32'(pending),    0);
        check("ar_err",   32'(err),        0);
        d_in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_valid", 32'(sync_valid), 0);
        check("post_pend",  32'(pending),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
